// File: rtl/wfc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wfc_pkg : shared state type and constants for weight_fetch_ctrl  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package wfc_pkg;

  localparam int C_CNT_W       = 16;
  localparam int C_ABS_ADDR_DW = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    FETCH     = 3'd2,
    FOLD_WAIT = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Number of column folds needed to cover num kernels with den columns.
  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wfc_valid_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wfc_valid_pipe : DEPTH-stage delay line for the {valid, last} tag |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module wfc_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [DEPTH-1:0] r_valid_sr;
  logic [DEPTH-1:0] r_last_sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid_sr <= '0;
          r_last_sr  <= '0;
        end else begin
          r_valid_sr <= in_valid;
          r_last_sr  <= in_last;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid_sr <= '0;
          r_last_sr  <= '0;
        end else begin
          r_valid_sr <= {r_valid_sr[DEPTH-2:0], in_valid};
          r_last_sr  <= {r_last_sr[DEPTH-2:0], in_last};
        end
      end
    end
  endgenerate

  assign out_valid = r_valid_sr[DEPTH-1];
  assign out_last  = r_last_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/weight_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | weight_fetch_ctrl : folds kernels over COLS ROMs, issues reads    |
// | Optional: WFC_STALL_CNT_EN adds the stall_cycles counter output   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module weight_fetch_ctrl
  import wfc_pkg::*;
#(
  parameter int COLS        = 8,
  parameter int ABS_ADDR_DW = C_ABS_ADDR_DW,
  parameter int CNT_W       = C_CNT_W,
  parameter int RD_LAT      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       kernel_num,
  input  logic [CNT_W-1:0]       kernel_elem,
  input  logic [ABS_ADDR_DW-1:0] base_addr_in,
  input  logic                   mem_sig,
  input  logic                   stall,
  input  logic                   fold_ack,
  output logic                   initial_sig,
  output logic [CNT_W-1:0]       addr_r,
  output logic [ABS_ADDR_DW-1:0] base_addr,
  output logic [CNT_W-1:0]       rom_select,
  output logic                   data_out_valid,
  output logic                   wt_valid,
  output logic                   wt_last,
  output logic                   busy,
  output logic                   done,
`ifdef WFC_STALL_CNT_EN
  output logic [31:0]            stall_cycles,
`endif
  output logic                   err
);

  localparam logic [CNT_W:0] C_COLS_EXT = (CNT_W+1)'(COLS);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_kernel_num;
  logic [CNT_W-1:0]       r_kernel_elem;
  logic [ABS_ADDR_DW-1:0] r_base_start;

  logic                   w_accept;
  logic                   w_zero_job;
  logic                   w_issue;
  logic                   w_last_issue;
  logic [CNT_W:0]         w_next_sel;

  assign w_accept       = (r_state == IDLE) && start;
  assign w_zero_job     = (kernel_num == '0) || (kernel_elem == '0);
  assign w_issue        = (r_state == FETCH) && !stall;
  assign w_last_issue   = w_issue && (addr_r == (r_kernel_elem - CNT_W'(1)));
  // One extra bit so a fold stride past the top of the range ends the job.
  assign w_next_sel     = {1'b0, rom_select} + C_COLS_EXT;
  assign data_out_valid = w_issue;
  assign busy           = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_kernel_num  <= '0;
      r_kernel_elem <= '0;
      r_base_start  <= '0;
      addr_r        <= '0;
      base_addr     <= '0;
      rom_select    <= '0;
      initial_sig   <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      initial_sig <= 1'b0;
      done        <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_kernel_num  <= kernel_num;
            r_kernel_elem <= kernel_elem;
            r_base_start  <= base_addr_in;
            err           <= 1'b0;
            if (w_zero_job) begin
              err     <= 1'b1;
              r_state <= DONE;
            end else if (!mem_sig) begin
              initial_sig <= 1'b1;
              r_state     <= INIT;
            end else begin
              addr_r     <= '0;
              rom_select <= '0;
              base_addr  <= base_addr_in;
              r_state    <= FETCH;
            end
          end
        end
        INIT: begin
          if (mem_sig) begin
            addr_r     <= '0;
            rom_select <= '0;
            base_addr  <= r_base_start;
            r_state    <= FETCH;
          end
        end
        FETCH: begin
          if (w_issue) begin
            if (w_last_issue) begin
              addr_r  <= '0;
              r_state <= FOLD_WAIT;
            end else begin
              addr_r <= addr_r + CNT_W'(1);
            end
          end
        end
        FOLD_WAIT: begin
          if (fold_ack) begin
            if (w_next_sel >= {1'b0, r_kernel_num}) begin
              r_state <= DONE;
            end else begin
              rom_select <= w_next_sel[CNT_W-1:0];
              base_addr  <= base_addr + ABS_ADDR_DW'(r_kernel_elem);
              r_state    <= FETCH;
            end
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  wfc_valid_pipe #(
    .DEPTH(RD_LAT)
  ) u_valid_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (w_issue),
    .in_last  (w_last_issue),
    .out_valid(wt_valid),
    .out_last (wt_last)
  );

`ifdef WFC_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (w_accept) begin
      stall_cycles <= '0;
    end else if ((r_state == FETCH) && stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_weight_fetch_ctrl : job vector table, corner sequences and     |
// | randomized jobs checked against a fold/element job model          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_weight_fetch_ctrl;

  localparam int COLS   = 8;
  localparam int CW     = 16;
  localparam int AW     = 16;
  localparam int RD_LAT = 1;

  localparam int PH_FETCH = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_DONE1 = 2;
  localparam int PH_DONE2 = 3;
  localparam int PH_END   = 4;

  logic          clk          = 1'b0;
  logic          rst_n        = 1'b0;
  logic          start        = 1'b0;
  logic [CW-1:0] kernel_num   = '0;
  logic [CW-1:0] kernel_elem  = '0;
  logic [AW-1:0] base_addr_in = '0;
  logic          mem_sig      = 1'b1;
  logic          stall        = 1'b0;
  logic          fold_ack     = 1'b0;

  logic          initial_sig;
  logic [CW-1:0] addr_r;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] rom_select;
  logic          data_out_valid;
  logic          wt_valid;
  logic          wt_last;
  logic          busy;
  logic          done;
  logic          err;
`ifdef WFC_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  int n_pass  = 0;
  int n_total = 0;

  weight_fetch_ctrl #(
    .COLS(COLS), .ABS_ADDR_DW(AW), .CNT_W(CW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_num(kernel_num),
    .kernel_elem(kernel_elem), .base_addr_in(base_addr_in), .mem_sig(mem_sig),
    .stall(stall), .fold_ack(fold_ack), .initial_sig(initial_sig), .addr_r(addr_r),
    .base_addr(base_addr), .rom_select(rom_select), .data_out_valid(data_out_valid),
    .wt_valid(wt_valid), .wt_last(wt_last), .busy(busy), .done(done),
`ifdef WFC_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Runs one job from IDLE (called at posedge+1) with mem_sig high; the model tracks
  // fold/element position and checks every strobe and handshake output each cycle.
  task automatic run_job(input int kn, input int ke, input int base, input int stall_pct,
                         input int ack_dly_max, output int strobes, output int folds,
                         output int err_at_done);
    int nfold, f, e, ack_cnt, phase, cyc, stall_seen;
    bit zero, exp_dov, exp_last;
    bit pv[$];
    bit pl[$];
    zero        = (kn == 0) || (ke == 0);
    nfold       = zero ? 0 : (kn + COLS - 1) / COLS;
    strobes     = 0;
    folds       = 0;
    err_at_done = -1;
    f = 0; e = 0; ack_cnt = 0; stall_seen = 0; cyc = 0;
    for (int i = 0; i < RD_LAT; i++) begin
      pv.push_back(1'b0);
      pl.push_back(1'b0);
    end
    mem_sig = 1'b1; stall = 1'b0; fold_ack = 1'b0;
    start = 1'b1; kernel_num = CW'(kn); kernel_elem = CW'(ke); base_addr_in = AW'(base);
    @(posedge clk); #1;
    start = 1'b0;
    phase = zero ? PH_DONE1 : PH_FETCH;
    while (phase != PH_END && cyc < 3000) begin
      stall = ($urandom_range(99) < stall_pct);
      if (phase == PH_WAIT) fold_ack = (ack_cnt == 0);
      else fold_ack = ($urandom_range(3) == 0);
      if (phase != PH_DONE2 && $urandom_range(7) == 0) begin
        start = 1'b1;
        kernel_num = CW'($urandom); kernel_elem = CW'($urandom); base_addr_in = AW'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      exp_dov  = (phase == PH_FETCH) && !stall;
      exp_last = exp_dov && (e == ke - 1);
      check("data_out_valid", data_out_valid, exp_dov);
      check("wt_valid", wt_valid, pv.pop_front());
      check("wt_last", wt_last, pl.pop_front());
      pv.push_back(exp_dov);
      pl.push_back(exp_last);
      check("busy", busy, phase != PH_DONE2);
      check("done", done, phase == PH_DONE2);
      check("err", err, zero);
      if (phase == PH_FETCH && stall) stall_seen++;
      if (exp_dov) begin
        check("addr_r", addr_r, e);
        check("rom_select", rom_select, f * COLS);
        check("base_addr", base_addr, (base + f * ke) & 32'hFFFF);
        strobes++;
        if (exp_last) begin
          e = 0;
          phase = PH_WAIT;
          ack_cnt = $urandom_range(ack_dly_max);
        end else begin
          e++;
        end
      end else if (phase == PH_WAIT) begin
        if (fold_ack) begin
          folds++;
          f++;
          phase = (f == nfold) ? PH_DONE1 : PH_FETCH;
        end else begin
          ack_cnt--;
        end
      end else if (phase == PH_DONE1) begin
        phase = PH_DONE2;
      end else if (phase == PH_DONE2) begin
        err_at_done = int'(err);
        phase = PH_END;
      end
      cyc++;
      if (phase != PH_END) begin
        @(posedge clk); #1;
      end
    end
    check("job_complete", phase, PH_END);
`ifdef WFC_STALL_CNT_EN
    check("stall_cycles", stall_cycles, stall_seen);
`endif
    start = 1'b0; stall = 1'b0; fold_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  // Holds fold_ack until done is seen, bounded.
  task automatic finish_job(input string name);
    bit seen;
    seen = 1'b0;
    fold_ack = 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = done;
      @(posedge clk); #1;
    end
    fold_ack = 1'b0;
    check(name, seen, 1'b1);
  endtask

  typedef struct {
    int kn;
    int ke;
    int base;
    int exp_strobes;
    int exp_folds;
    int exp_err;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int s, fo, er, cnt_pulse, cnt_strobe, cnt_wv, last_idx, done_seen;
    int kn, ke;
    int stall_pat[8];
    int exp_addr[8];
    int exp_dov[8];

    vecs[0] = '{6,  4, 16'h0010, 4, 1, 0};
    vecs[1] = '{20, 3, 16'h0000, 9, 3, 0};
    vecs[2] = '{0,  5, 16'h0022, 0, 0, 1};
    vecs[3] = '{7,  0, 16'h0022, 0, 0, 1};
    vecs[4] = '{8,  2, 16'h0005, 2, 1, 0};
    vecs[5] = '{9,  1, 16'hFFFE, 2, 2, 0};
    vecs[6] = '{16, 3, 16'd100,  6, 2, 0};
    vecs[7] = '{17, 2, 16'h0000, 6, 3, 0};
    stall_pat = '{0, 1, 0, 1, 0, 0, 1, 0};
    exp_addr  = '{0, 1, 1, 2, 2, 3, 4, 4};
    exp_dov   = '{1, 0, 1, 0, 1, 1, 0, 1};

    // Reset state
    #12;
    check("rst_flags", {initial_sig, data_out_valid, wt_valid, wt_last, busy, done, err}, 7'd0);
    check("rst_addr_sel", {addr_r, rom_select}, 32'd0);
    check("rst_base", base_addr, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Job vector table, no stall, immediate acknowledge
    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].kn, vecs[i].ke, vecs[i].base, 0, 0, s, fo, er);
      check("vec_strobes", s, vecs[i].exp_strobes);
      check("vec_folds", fo, vecs[i].exp_folds);
      check("vec_err", er, vecs[i].exp_err);
    end

    // ROM initialisation handshake
    mem_sig = 1'b0; start = 1'b1; kernel_num = 16'd6; kernel_elem = 16'd2; base_addr_in = 16'h0040;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("init_pulse_first", initial_sig, 1'b1);
    check("init_busy", busy, 1'b1);
    cnt_pulse = 0; cnt_strobe = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      cnt_pulse  += int'(initial_sig);
      cnt_strobe += int'(data_out_valid);
    end
    check("init_pulse_once", cnt_pulse, 0);
    check("init_no_strobe", cnt_strobe, 0);
    @(posedge clk); #1; mem_sig = 1'b1;
    @(negedge clk);
    check("init_waits_mem_sig", data_out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("fetch_after_init", data_out_valid, 1'b1);
    check("fetch_after_init_addr", addr_r, 16'd0);
    check("fetch_after_init_base", base_addr, 16'h0040);
    @(posedge clk); #1;
    @(negedge clk);
    check("init_job_addr1", addr_r, 16'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("init_job_last", {wt_valid, wt_last, data_out_valid}, 3'b110);
    @(posedge clk); #1;
    finish_job("init_job_done");

    // Stall pattern over a 5-element fold, including a stall on the last element
    start = 1'b1; kernel_num = 16'd3; kernel_elem = 16'd5; base_addr_in = 16'h0000;
    @(posedge clk); #1; start = 1'b0;
    cnt_wv = 0; last_idx = 0;
    for (int i = 0; i < 8; i++) begin
      stall = stall_pat[i][0];
      @(negedge clk);
      check("stall_addr", addr_r, exp_addr[i]);
      check("stall_dov", data_out_valid, exp_dov[i]);
      if (wt_valid) begin
        cnt_wv++;
        if (wt_last) last_idx = cnt_wv;
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    if (wt_valid) begin
      cnt_wv++;
      if (wt_last) last_idx = cnt_wv;
    end
    check("stall_wt_valid_count", cnt_wv, 5);
    check("stall_wt_last_index", last_idx, 5);
`ifdef WFC_STALL_CNT_EN
    check("stall_cycles_hand", stall_cycles, 3);
`endif
    @(posedge clk); #1;
    finish_job("stall_job_done");

    // Asynchronous reset in the middle of the second fold
    start = 1'b1; kernel_num = 16'd20; kernel_elem = 16'd6; base_addr_in = 16'h0000;
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(posedge clk);
    #1; fold_ack = 1'b1;
    @(posedge clk); #1; fold_ack = 1'b0;
    @(negedge clk);
    check("fold2_rom_select", rom_select, 16'd8);
    check("fold2_base", base_addr, 16'd6);
    check("fold2_strobe", data_out_valid, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {initial_sig, data_out_valid, wt_valid, wt_last, busy, done, err}, 7'd0);
    check("mid_rst_addr_sel", {addr_r, rom_select}, 32'd0);
    check("mid_rst_base", base_addr, 16'd0);
    done_seen = 0;
    @(negedge clk); done_seen += int'(done);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      done_seen += int'(done) + int'(busy) + int'(wt_valid);
    end
    check("mid_rst_no_done", done_seen, 0);
    @(posedge clk); #1;
    run_job(20, 3, 0, 20, 2, s, fo, er);
    check("post_rst_strobes", s, 9);
    check("post_rst_folds", fo, 3);

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      kn = $urandom_range(40);
      ke = $urandom_range(9);
      run_job(kn, ke, $urandom_range(16'hFFFF), 30, 4, s, fo, er);
      check("rand_strobes", s, (kn == 0 || ke == 0) ? 0 : ((kn + COLS - 1) / COLS) * ke);
      check("rand_folds", fo, (kn == 0 || ke == 0) ? 0 : (kn + COLS - 1) / COLS);
      check("rand_err", er, (kn == 0 || ke == 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
- Sequencer for the multi-ROM weight store that feeds the systolic array's column inputs.
- Triggers and awaits ROM initialisation, then walks column folds of width COLS over kernel_num kernels. Per fold: kernel_elem element addresses, with base offset and ROM-select offset.
- Issues read strobes under array back-pressure and tags returned weight words with valid/last.
- Waits for a per-fold acknowledge from the array controller before starting the next fold.

Parameters:
- COLS, 8, systolic array columns (= ROMs read in parallel); fold stride for rom_select.
- ABS_ADDR_DW, 16, ROM absolute address width.
- CNT_W, 16, width of kernel_num, kernel_elem, addr_r and rom_select.
- RD_LAT, 1, ROM read latency in cycles, from data_out_valid to weight word present.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job start; sampled only in IDLE.
- kernel_num  in  CNT_W  total kernels (output channels); latched on start.
- kernel_elem  in  CNT_W  elements per kernel (K*K*Cin); latched on start.
- base_addr_in  in  ABS_ADDR_DW  base address of fold 0; latched on start.
- mem_sig  in  1  ROM initialisation complete (level).
- stall  in  1  array back-pressure; no read is issued while high.
- fold_ack  in  1  array has consumed the current fold; honoured only in FOLD_WAIT.
- initial_sig  out  1  ROM init request pulse.
- addr_r  out  CNT_W  element address within the kernel.
- base_addr  out  ABS_ADDR_DW  current fold base address.
- rom_select  out  CNT_W  first kernel index of the current fold.
- data_out_valid  out  1  ROM read strobe.
- wt_valid  out  1  weight word valid, RD_LAT cycles after the strobe.
- wt_last  out  1  with wt_valid: last element of the fold.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle job-complete pulse.
- err  out  1  sticky zero-size job flag; cleared by the next start.

Behaviour:
- Reset value of all outputs and registers is 0; state is IDLE.
- States: IDLE, INIT, FETCH, FOLD_WAIT, DONE.
- IDLE:
  - On start, latch kernel_num, kernel_elem and base_addr_in; set err=0.
  - If kernel_num==0 or kernel_elem==0: set err=1 and go to DONE.
  - Else if mem_sig==0: go to INIT. Else go to FETCH with addr_r=0, rom_select=0, base_addr=base_addr_in.
- INIT:
  - initial_sig=1 for exactly the first cycle in the state.
  - Remain in INIT until mem_sig==1, then go to FETCH with the counters zeroed as above.
- FETCH:
  - data_out_valid = ~stall, combinational from state and stall.
  - A read issues on each cycle with data_out_valid=1. addr_r advances after each issue; it holds while stall=1.
  - The issue at addr_r==kernel_elem-1 is the last issue: addr_r clears to 0 and the next state is FOLD_WAIT.
- FOLD_WAIT:
  - No issue.
  - On fold_ack, if rom_select+COLS >= kernel_num: go to DONE.
  - Otherwise rom_select += COLS, base_addr += kernel_elem, and go to FETCH.
  - Compute rom_select+COLS at CNT_W+1 bits; no wrap.
- DONE: done=1 for one cycle, then IDLE. Latched values persist.
- Valid pipeline:
  - wt_valid is data_out_valid delayed by RD_LAT cycles through a shift register.
  - wt_last is the last-issue flag delayed by the same RD_LAT cycles.
  - The pipeline drains normally after a state change.
- Fold count = ceil(kernel_num/COLS). The ROM gates non-existent kernels in a partial last fold; this block does not mask them.
- Precedence and boundary cases:
  - start outside IDLE is ignored.
  - fold_ack outside FOLD_WAIT is ignored.
  - fold_ack and stall in the same cycle: fold_ack wins; stall only affects FETCH.
  - stall on the last-element cycle: the last issue is deferred.
- Asynchronous reset mid-job: return to IDLE immediately, clear the valid pipeline, and do not pulse done.

Optional Feature:
- Macro WFC_STALL_CNT_EN.
- When defined: adds output stall_cycles (32 bits).
  - Counts cycles in FETCH with stall=1.
  - Cleared on accepted start; saturates at all-ones.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package wfc_pkg holds the state enum (IDLE/INIT/FETCH/FOLD_WAIT/DONE), default CNT_W/ABS_ADDR_DW localparams, and a ceil-div function for the fold count.
- One natural sub-module, wfc_valid_pipe: the RD_LAT-deep shift register carrying {valid, last}.
- FSM and counters stay in the top module.

Test Plan:
- kernel_num=6, kernel_elem=4, COLS=8, base=0x10, mem_sig=1, no stall:
  - 4 strobes with addr_r 0,1,2,3 and rom_select=0, base_addr=0x10.
  - wt_last on the 4th wt_valid, 1 cycle after its strobe.
  - After fold_ack, done pulses; exactly one fold.
- kernel_num=20, kernel_elem=3, base=0:
  - 3 folds with rom_select 0,8,16 and base_addr 0,3,6.
  - Each fold starts only after fold_ack; done follows the 3rd ack.
- mem_sig=0 at start:
  - initial_sig pulses exactly 1 cycle and no strobes appear.
  - mem_sig raised 10 cycles later: FETCH begins the next cycle.
- kernel_elem=5, stall high on the 2nd and 4th FETCH cycles:
  - addr_r sequence 0,1,1,2,2,3,4.
  - Exactly 5 wt_valid; wt_last on the 5th.
- kernel_num=0 -> err=1, done pulse 2 cycles after start, no strobes. kernel_elem=0 -> same response.
- Reset asserted mid-FETCH of fold 2 -> all outputs 0 and IDLE on the next edge, no done. A subsequent start runs a clean job.
